// File: rtl/zimbo_pkg.sv
// Shared encodings for the Zimbo control sequencer: opcodes, ALU ops, PC
// sources, register-read address sources and FSM state encodings.
// Imported by the FSM, the memory wait timer and the testbench.
package zimbo_pkg;

  // Cycles a memory request may wait for mem_ready before aborting.
  localparam int MEM_TIMEOUT = 16;

  // Opcodes (IR[15:11]); everything above OP_MUL is illegal.
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00001;
  localparam logic [4:0] OP_LW    = 5'b00010;
  localparam logic [4:0] OP_SW    = 5'b00011;
  localparam logic [4:0] OP_BEQ   = 5'b00100;
  localparam logic [4:0] OP_BNE   = 5'b00101;
  localparam logic [4:0] OP_JMP   = 5'b00110;
  localparam logic [4:0] OP_MUL   = 5'b00111;

  // ALU operations (RTYPE passes func straight through).
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_MULLO = 3'b110;
  localparam logic [2:0] ALU_MULHI = 3'b111;

  // PC source select.
  localparam logic [1:0] PC_IN     = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  // Register-read address-1 source.
  localparam logic [1:0] AB_FETCH = 2'd0;
  localparam logic [1:0] AB_RS    = 2'd1;
  localparam logic [1:0] AB_HI    = 2'd2;

  // FSM state encodings.
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_WB_HI  = 3'd5;

  typedef enum logic [2:0] {
    S_FETCH  = ST_FETCH,
    S_DECODE = ST_DECODE,
    S_EXEC   = ST_EXEC,
    S_MEM    = ST_MEM,
    S_WB     = ST_WB,
    S_WB_HI  = ST_WB_HI
  } state_t;

  function automatic logic op_legal(input logic [4:0] op);
    return (op <= OP_MUL);
  endfunction

endpackage

// File: rtl/zimbo_mem_timer.sv
// Purpose: counts consecutive cycles a memory request waits for mem_ready.
// Latency: expired is combinational in the LIMIT-th waiting cycle.
// Backpressure: none of its own; it only observes the FSM's wait condition.
// Ports: clk/rst_n (sync, active-low), start (clear on FETCH/MEM entry),
//        waiting (request pending, no ready), expired (abort this cycle).
module zimbo_mem_timer
  import zimbo_pkg::*;
#(
  parameter int LIMIT = MEM_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic waiting,
  output logic expired
);

  localparam int W = $clog2(LIMIT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      cnt <= '0;
    end else if (waiting) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt holds the number of earlier waiting cycles, so the LIMIT-th waiting
  // cycle sees LIMIT-1. A ready in that cycle clears waiting and wins.
  assign expired = waiting && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/zimbo_ctrl_fsm.sv
// Purpose: multi-cycle control sequencer for the Zimbo 16-bit datapath.
// Latency: RTYPE/ADDI/SW 4, LW/MUL 5, BEQ/BNE/JMP 3, illegal 2 cycles at zero wait.
// Backpressure: stalls in FETCH/MEM while mem_ready is low; aborts after MEM_TIMEOUT.
// Ports: opcode/func/rdestBit0 from IR, zero from ALU, mem_ready from memory;
//        outputs are datapath selects, PC/IR/regfile strobes, memory request, illegal.
module zimbo_ctrl_fsm
  import zimbo_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] opcode,
  input  logic [2:0] func,
  input  logic       rdestBit0,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       irwrite,
  output logic       pcwrite,
  output logic [1:0] pcsrc,
  output logic       mem_req,
  output logic       mem_we,
  output logic       insdat,
  output logic       mem_alu,
  output logic       alusrc,
  output logic       mulreg,
  output logic [1:0] addrbase,
  output logic [2:0] aluop,
  output logic       regwrite,
  output logic       illegal
);

  state_t state, state_nxt;
  logic   mem_phase, waiting, expired, timer_start;
  logic   is_sw;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  assign mem_phase = (state == S_FETCH) || (state == S_MEM);
  assign waiting   = mem_phase && !mem_ready;
  assign is_sw     = (opcode == OP_SW);

  // Clear the wait counter whenever a fresh access begins, including the
  // FETCH -> FETCH restart after a timeout.
  assign timer_start = ((state_nxt == S_FETCH) || (state_nxt == S_MEM)) &&
                       ((state_nxt != state) || expired);

  zimbo_mem_timer #(
    .LIMIT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (timer_start),
    .waiting(waiting),
    .expired(expired)
  );

  always_comb begin
    state_nxt = state;
    irwrite   = 1'b0;
    pcwrite   = 1'b0;
    pcsrc     = PC_IN;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    insdat    = 1'b0;
    mem_alu   = 1'b0;
    alusrc    = 1'b0;
    mulreg    = 1'b0;
    addrbase  = AB_RS;
    aluop     = ALU_ADD;
    regwrite  = 1'b0;
    illegal   = 1'b0;

    case (state)
      S_FETCH: begin
        addrbase = AB_FETCH;
        mem_req  = 1'b1;
        if (mem_ready) begin
          irwrite   = 1'b1;
          pcwrite   = 1'b1;
          pcsrc     = PC_IN;
          state_nxt = S_DECODE;
        end else if (expired) begin
          illegal   = 1'b1;
          state_nxt = S_FETCH;
        end
      end

      S_DECODE: begin
        alusrc = 1'b1;
        if (!op_legal(opcode) || ((opcode == OP_MUL) && rdestBit0)) begin
          illegal   = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_EXEC;
        end
      end

      S_EXEC: begin
        case (opcode)
          OP_RTYPE: begin
            alusrc    = 1'b1;
            aluop     = func;
            state_nxt = S_WB;
          end
          OP_MUL: begin
            alusrc    = 1'b1;
            state_nxt = S_WB;
          end
          OP_ADDI: begin
            aluop     = ALU_ADD;
            state_nxt = S_WB;
          end
          OP_LW, OP_SW: begin
            aluop     = ALU_ADD;
            state_nxt = S_MEM;
          end
          OP_BEQ: begin
            alusrc    = 1'b1;
            aluop     = ALU_SUB;
            pcsrc     = PC_BRANCH;
            pcwrite   = zero;
            state_nxt = S_FETCH;
          end
          OP_BNE: begin
            alusrc    = 1'b1;
            aluop     = ALU_SUB;
            pcsrc     = PC_BRANCH;
            pcwrite   = !zero;
            state_nxt = S_FETCH;
          end
          OP_JMP: begin
            pcwrite   = 1'b1;
            pcsrc     = PC_JUMP;
            state_nxt = S_FETCH;
          end
          default: state_nxt = S_FETCH;
        endcase
      end

      S_MEM: begin
        insdat  = 1'b1;
        mem_req = 1'b1;
        aluop   = ALU_ADD;
        alusrc  = 1'b0;
        // Write strobe is withdrawn in the abort cycle so nothing is stored.
        mem_we  = is_sw && !expired;
        if (mem_ready) begin
          state_nxt = is_sw ? S_FETCH : S_WB;
        end else if (expired) begin
          illegal   = 1'b1;
          state_nxt = S_FETCH;
        end
      end

      S_WB: begin
        regwrite = 1'b1;
        mem_alu  = (opcode == OP_LW);
        if (opcode == OP_MUL) begin
          aluop     = ALU_MULLO;
          state_nxt = S_WB_HI;
        end else begin
          state_nxt = S_FETCH;
        end
      end

      S_WB_HI: begin
        regwrite  = 1'b1;
        aluop     = ALU_MULHI;
        mulreg    = 1'b1;
        addrbase  = AB_HI;
        state_nxt = S_FETCH;
      end

      default: state_nxt = S_FETCH;
    endcase

    // Outputs are forced quiet while reset is asserted, whatever the state.
    if (!rst_n) begin
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      pcsrc    = 2'd0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      insdat   = 1'b0;
      mem_alu  = 1'b0;
      alusrc   = 1'b0;
      mulreg   = 1'b0;
      addrbase = 2'd0;
      aluop    = 3'd0;
      regwrite = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_zimbo_ctrl_fsm.sv
// Self-checking bench for zimbo_ctrl_fsm: directed scenarios followed by
// randomized instruction streams. Each instruction is expanded into the
// expected per-cycle output trace and the memory-ready pattern to drive.
module tb_zimbo_ctrl_fsm;
  import zimbo_pkg::*;

  typedef struct packed {
    logic       irwrite;
    logic       pcwrite;
    logic [1:0] pcsrc;
    logic       mem_req;
    logic       mem_we;
    logic       insdat;
    logic       mem_alu;
    logic       alusrc;
    logic       mulreg;
    logic [1:0] addrbase;
    logic [2:0] aluop;
    logic       regwrite;
    logic       illegal;
  } ovec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] opcode;
  logic [2:0] func;
  logic       rdestBit0, zero, mem_ready;
  logic       irwrite, pcwrite, mem_req, mem_we, insdat, mem_alu;
  logic       alusrc, mulreg, regwrite, illegal;
  logic [1:0] pcsrc, addrbase;
  logic [2:0] aluop;

  ovec_t got;
  assign got = {irwrite, pcwrite, pcsrc, mem_req, mem_we, insdat, mem_alu,
                alusrc, mulreg, addrbase, aluop, regwrite, illegal};

  zimbo_ctrl_fsm dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .func     (func),
    .rdestBit0(rdestBit0),
    .zero     (zero),
    .mem_ready(mem_ready),
    .irwrite  (irwrite),
    .pcwrite  (pcwrite),
    .pcsrc    (pcsrc),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .insdat   (insdat),
    .mem_alu  (mem_alu),
    .alusrc   (alusrc),
    .mulreg   (mulreg),
    .addrbase (addrbase),
    .aluop    (aluop),
    .regwrite (regwrite),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  int    n_chk  = 0;
  int    n_pass = 0;
  ovec_t exp_q[$];
  bit    rdy_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_chk++;
    if (got_v === exp_v) n_pass++;
    else $display("FAIL %s: got %05h expected %05h", tag, got_v, exp_v);
  endtask

  function automatic void push(input ovec_t v, input bit r);
    exp_q.push_back(v);
    rdy_q.push_back(r);
  endfunction

  // Waiting cycles of a memory access: ready held low; the MEM_TIMEOUT-th
  // waiting cycle is the abort cycle (illegal, no write strobe).
  task automatic wait_cycles(input ovec_t base, input int w, output bit timed_out);
    ovec_t v;
    timed_out = (w >= MEM_TIMEOUT);
    for (int i = 0; i < w && i < MEM_TIMEOUT; i++) begin
      v = base;
      if (i == MEM_TIMEOUT - 1) begin
        v.illegal = 1'b1;
        v.mem_we  = 1'b0;
      end
      push(v, 1'b0);
    end
  endtask

  // Expected behaviour of one instruction, cycle by cycle.
  task automatic plan(input logic [4:0] op, input logic [2:0] fn, input logic rd0,
                      input logic z, input int fw, input int mw);
    ovec_t v, base;
    bit    to;
    bit    bad;
    bad = (op > 5'd7) || ((op == OP_MUL) && rd0);
    exp_q.delete();
    rdy_q.delete();

    base = '0;
    base.mem_req = 1'b1;
    wait_cycles(base, fw, to);
    if (to) return;
    v = base;
    v.irwrite = 1'b1;
    v.pcwrite = 1'b1;
    push(v, 1'b1);

    v = '0;
    v.addrbase = 2'd1;
    v.alusrc   = 1'b1;
    v.illegal  = bad;
    push(v, 1'($urandom));
    if (bad) return;

    v = '0;
    v.addrbase = 2'd1;
    case (op)
      OP_RTYPE: begin v.alusrc = 1'b1; v.aluop = fn; end
      OP_MUL:   v.alusrc = 1'b1;
      OP_BEQ:   begin v.alusrc = 1'b1; v.aluop = 3'b001; v.pcsrc = 2'd1; v.pcwrite = z; end
      OP_BNE:   begin v.alusrc = 1'b1; v.aluop = 3'b001; v.pcsrc = 2'd1; v.pcwrite = !z; end
      OP_JMP:   begin v.pcwrite = 1'b1; v.pcsrc = 2'd2; end
      default:  v.aluop = 3'b000;
    endcase
    push(v, 1'($urandom));
    if (op == OP_BEQ || op == OP_BNE || op == OP_JMP) return;

    if (op == OP_LW || op == OP_SW) begin
      base = '0;
      base.addrbase = 2'd1;
      base.insdat   = 1'b1;
      base.mem_req  = 1'b1;
      base.mem_we   = (op == OP_SW);
      wait_cycles(base, mw, to);
      if (to) return;
      push(base, 1'b1);
      if (op == OP_SW) return;
    end

    v = '0;
    v.addrbase = 2'd1;
    v.regwrite = 1'b1;
    v.mem_alu  = (op == OP_LW);
    if (op == OP_MUL) v.aluop = 3'b110;
    push(v, 1'($urandom));

    if (op == OP_MUL) begin
      v = '0;
      v.regwrite = 1'b1;
      v.aluop    = 3'b111;
      v.mulreg   = 1'b1;
      v.addrbase = 2'd2;
      push(v, 1'($urandom));
    end
  endtask

  // Called at a falling edge: hold reset for three rising edges, checking
  // that every output stays low, then release just after the third edge.
  task automatic reset_hold(input string nm);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = 1'($urandom);
      #1 check_eq($sformatf("%s rst%0d", nm, i), 32'(got), 32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic play(input string nm, input logic [4:0] op, input logic [2:0] fn,
                      input logic rd0, input logic z, input int fw, input int mw,
                      input int rst_at);
    plan(op, fn, rd0, z, fw, mw);
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge clk);
      if (c == 0) begin
        opcode    = op;
        func      = fn;
        rdestBit0 = rd0;
        zero      = z;
      end
      if (c == rst_at) begin
        reset_hold(nm);
        return;
      end
      mem_ready = rdy_q[c];
      #1 check_eq($sformatf("%s c%0d", nm, c), 32'(got), 32'(exp_q[c]));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = '0;
    func      = '0;
    rdestBit0 = 1'b0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    #1 check_eq("init_rst", 32'(got), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed scenarios.
    play("add_rst_exec", OP_RTYPE, 3'b000, 1'b1, 1'b0, 0, 0, 2);
    play("add_r3",       OP_RTYPE, 3'b000, 1'b1, 1'b0, 0, 0, -1);
    play("lw_wait2",     OP_LW,    3'b000, 1'b0, 1'b0, 0, 2, -1);
    play("beq_z0",       OP_BEQ,   3'b000, 1'b0, 1'b0, 0, 0, -1);
    play("beq_z1",       OP_BEQ,   3'b000, 1'b0, 1'b1, 0, 0, -1);
    play("bne_z0",       OP_BNE,   3'b000, 1'b0, 1'b0, 1, 0, -1);
    play("jmp",          OP_JMP,   3'b000, 1'b0, 1'b0, 0, 0, -1);
    play("mul_ok",       OP_MUL,   3'b000, 1'b0, 1'b0, 0, 0, -1);
    play("mul_bad",      OP_MUL,   3'b000, 1'b1, 1'b0, 0, 0, -1);
    play("op_11111",     5'b11111, 3'b000, 1'b0, 1'b0, 0, 0, -1);
    play("fetch_to16",   OP_ADDI,  3'b000, 1'b0, 1'b0, 16, 0, -1);
    play("fetch_rdy15",  OP_ADDI,  3'b000, 1'b0, 1'b0, 15, 0, -1);
    play("sw_to16",      OP_SW,    3'b000, 1'b0, 1'b0, 0, 16, -1);
    play("lw_rdy15",     OP_LW,    3'b000, 1'b0, 1'b0, 0, 15, -1);
    play("sw_wait1",     OP_SW,    3'b000, 1'b0, 1'b0, 0, 1, -1);
    play("mul_rst_wb",   OP_MUL,   3'b000, 1'b0, 1'b0, 0, 0, 3);
    play("after_rst",    OP_RTYPE, 3'b101, 1'b0, 1'b0, 0, 0, -1);

    // Randomized instruction stream.
    for (int n = 0; n < 300; n++) begin
      logic [4:0] op;
      int         fw, mw, rst_at, r;
      op = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(8, 31));
      r  = $urandom_range(0, 99);
      fw = (r < 3) ? 16 + $urandom_range(0, 2) : (r < 6) ? 15 : $urandom_range(0, 3);
      r  = $urandom_range(0, 99);
      mw = (r < 3) ? 16 + $urandom_range(0, 2) : (r < 6) ? 15 : $urandom_range(0, 3);
      rst_at = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 6) : -1;
      play($sformatf("rnd%0d", n), op, 3'($urandom), 1'($urandom), 1'($urandom),
           fw, mw, rst_at);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/zimbo_ctrl_fsm.md
# zimbo_ctrl_fsm

Multi-cycle control sequencer for the Zimbo 16-bit datapath. Decodes the instruction-register fields (opcode, func, rdestBit0) and, state by state, drives every datapath select line (mem_alu, addrbase, mulreg, insdat, alusrc) plus the PC, IR, register-file and memory strobes. It sits between the datapath and a single shared instruction/data memory port with a ready handshake, and stalls on that port as needed.

## Interface
- MEM_TIMEOUT, 16: cycles a mem_req may wait for mem_ready before the FSM aborts to FETCH and raises illegal.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- opcode  in  5  IR[15:11].
- func  in  3  IR[2:0].
- rdestBit0  in  1  IR[7], low bit of destination register.
- zero  in  1  ALU result==0, combinational, valid in EXEC.
- mem_ready  in  1  memory completes the current access this cycle.
- irwrite, pcwrite  out  1  each, load IR / load PC.
- pcsrc  out  2  0 pcin, 1 pcbranch, 2 pcjump.
- mem_req, mem_we  out  1  each, memory access request / write.
- insdat, mem_alu, alusrc, mulreg  out  1  each, datapath selects.
- addrbase  out  2  register-read address-1 source.
- aluop  out  3  ALU operation.
- regwrite  out  1  register-file write strobe.
- illegal  out  1  one-cycle pulse on bad opcode, bad MUL destination or memory timeout.

## Operation
- Opcodes: RTYPE 00000, ADDI 00001, LW 00010, SW 00011, BEQ 00100, BNE 00101, JMP 00110, MUL 00111; all others illegal.
- aluop: ADD 000, SUB 001; RTYPE passes func; MULLO 110, MULHI 111.
- States: FETCH, DECODE, EXEC, MEM, WB, WB_HI.
- FETCH: insdat=0, mem_req=1; hold until mem_ready; on ready irwrite=1, pcwrite=1, pcsrc=0 -> DECODE.
- DECODE: addrbase=1, alusrc=1; illegal opcode, or MUL with rdestBit0=1 -> illegal pulse, -> FETCH. Otherwise -> EXEC.
- EXEC: RTYPE/MUL alusrc=1; ADDI/LW/SW alusrc=0, aluop=ADD; BEQ/BNE alusrc=1, aluop=SUB.
  - BEQ: pcwrite=zero, pcsrc=1. BNE: pcwrite=!zero, pcsrc=1. Either -> FETCH.
  - JMP: pcwrite=1, pcsrc=2 -> FETCH.
  - LW/SW -> MEM; RTYPE/ADDI/MUL -> WB.
- MEM: insdat=1, mem_req=1, mem_we=(SW), aluop=ADD, alusrc=0 held; on mem_ready LW -> WB, SW -> FETCH.
- WB: regwrite=1; mem_alu=1 for LW, else 0; MUL aluop=MULLO, mulreg=0 -> WB_HI; else -> FETCH.
- WB_HI: regwrite=1, aluop=MULHI, mulreg=1, addrbase=2 -> FETCH.
- Outputs not listed for a state are 0. addrbase defaults to 1 outside FETCH.

## Timing
- Outputs are combinational from the registered state and inputs. There are no registered outputs apart from state and the timeout counter.
- Zero-wait memory gives these cycle counts: RTYPE/ADDI 4, SW 4, LW 5, MUL 5, BEQ/BNE/JMP 3, illegal 2.
- Each extra mem_ready-low cycle adds one cycle in FETCH or MEM. Request signals stay stable while waiting.
- Timeout counter:
  - Cleared on entry to FETCH and to MEM.
  - Increments each waiting cycle.
  - At MEM_TIMEOUT with no ready: illegal pulses, -> FETCH, and no irwrite, pcwrite, regwrite or mem_we.
  - A ready in the same cycle as the limit wins.
- Reset: while rst_n=0, every output is 0. Next state is FETCH and the counter is 0. A reset asserted in any state, including mid-MUL between WB and WB_HI, abandons the instruction on the next edge.
- Signals never asserted together: pcwrite and regwrite; irwrite outside FETCH; mem_we outside MEM.

## Structure
- Package zimbo_pkg holds the opcode, aluop, pcsrc and state encodings as localparams, shared with the decoder and the testbench.
- One sub-module, zimbo_mem_timer: the wait/timeout counter. It has start, waiting and expired ports.

## Test plan
- Reset held 3 cycles mid-EXEC, then released -> all outputs 0 during reset; first cycle after release is FETCH with mem_req=1.
- ADD r3 (RTYPE, func 000) with mem_ready=1 -> regwrite high exactly in cycle 4, mem_alu=0, aluop=000.
- LW with mem_ready low for 2 cycles in MEM -> insdat=1 held 3 cycles; regwrite at cycle 7 with mem_alu=1.
- BEQ with zero=0, then zero=1 -> pcwrite=0 in EXEC, then pcwrite=1 with pcsrc=1; both return to FETCH in 3 cycles.
- MUL with rdestBit0=0 -> WB (mulreg=0, aluop=110) then WB_HI (mulreg=1, aluop=111, addrbase=2). With rdestBit0=1 -> illegal pulse in DECODE, no regwrite.
- Opcode 11111, and FETCH with mem_ready stuck low for 16 cycles -> illegal pulses once each; no state change other than returning to FETCH.
